// File: rtl/ddr_preload_packer.sv
// Fetches NUM_WORDS source words, packs them little-endian into DATA_W beats and writes them to DDR.
// Optional read-back verification of the written beats is enabled with `define DDR_PRELOAD_VERIFY_EN.
module ddr_preload_packer #(
  parameter int WORD_W    = 32,
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 25,
  parameter int NUM_WORDS = 28,
  parameter int BASE_ADDR = 0,
  parameter int SRC_AW    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [SRC_AW-1:0]   src_addr,
  input  logic [WORD_W-1:0]   src_data,
  output logic                wr_rq,
  output logic [ADDR_W-1:0]   wr_adr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] byte_enable,
  input  logic                action_done,
  output logic                busy,
  output logic                setup_done,
  output logic [15:0]         beat_cnt
`ifdef DDR_PRELOAD_VERIFY_EN
  ,
  output logic                rd_rq,
  output logic [ADDR_W-1:0]   rd_adr,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_valid,
  output logic                verify_fail
`endif
);

  localparam int LANES      = DATA_W / WORD_W;
  localparam int LANE_BYTES = WORD_W / 8;
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WIDX_W     = SRC_AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PACK,
    WRITE,
    WAIT_ACK,
    DONE
`ifdef DDR_PRELOAD_VERIFY_EN
    ,
    VERIFY,
    VERIFY_WAIT
`endif
  } state_t;

  state_t              state, next_state;
  logic                start_q;
  logic [WIDX_W-1:0]   w;
  logic [LANE_W-1:0]   lane;
  logic [DATA_W-1:0]   pack_reg;
  logic [LANES-1:0]    lane_mask;
  logic [DATA_W/8-1:0] mask_bytes;
  logic                start_edge;
  logic                beat_full;
  logic                words_left;

  assign start_edge = start & ~start_q;
  assign beat_full  = (lane == LANE_W'(LANES - 1)) || (w == WIDX_W'(NUM_WORDS - 1));
  assign words_left = (w != WIDX_W'(NUM_WORDS));
  assign src_addr   = w[SRC_AW-1:0];

  always_comb begin
    mask_bytes = '0;
    for (int l = 0; l < LANES; l++)
      mask_bytes[l*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{lane_mask[l]}};
  end

`ifdef DDR_PRELOAD_VERIFY_EN
  logic              verifying;
  logic [DATA_W-1:0] mask_bits;

  always_comb begin
    mask_bits = '0;
    for (int l = 0; l < LANES; l++)
      mask_bits[l*WORD_W +: WORD_W] = {WORD_W{lane_mask[l]}};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_edge) next_state = FETCH;
      FETCH:    next_state = PACK;
      PACK: begin
        if (beat_full) begin
`ifdef DDR_PRELOAD_VERIFY_EN
          next_state = verifying ? VERIFY : WRITE;
`else
          next_state = WRITE;
`endif
        end else begin
          next_state = FETCH;
        end
      end
      WRITE:    next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (action_done) begin
`ifdef DDR_PRELOAD_VERIFY_EN
          // The read-back pass reuses FETCH/PACK to rebuild each expected beat
          next_state = FETCH;
`else
          next_state = words_left ? FETCH : DONE;
`endif
        end
      end
`ifdef DDR_PRELOAD_VERIFY_EN
      VERIFY:      next_state = VERIFY_WAIT;
      VERIFY_WAIT: if (rd_valid) next_state = words_left ? FETCH : DONE;
`endif
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      w           <= '0;
      lane        <= '0;
      pack_reg    <= '0;
      lane_mask   <= '0;
      wr_rq       <= 1'b0;
      wr_adr      <= ADDR_W'(BASE_ADDR);
      wr_data     <= '0;
      byte_enable <= '0;
      busy        <= 1'b0;
      setup_done  <= 1'b0;
      beat_cnt    <= '0;
`ifdef DDR_PRELOAD_VERIFY_EN
      verifying   <= 1'b0;
      rd_rq       <= 1'b0;
      rd_adr      <= '0;
      verify_fail <= 1'b0;
`endif
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            setup_done <= 1'b0;
            busy       <= 1'b1;
            w          <= '0;
            lane       <= '0;
            beat_cnt   <= '0;
            wr_adr     <= ADDR_W'(BASE_ADDR);
            pack_reg   <= '0;
            lane_mask  <= '0;
`ifdef DDR_PRELOAD_VERIFY_EN
            verifying   <= 1'b0;
            verify_fail <= 1'b0;
`endif
          end
        end
        PACK: begin
          pack_reg[lane*WORD_W +: WORD_W] <= src_data;
          lane_mask[lane]                 <= 1'b1;
          w                               <= w + WIDX_W'(1);
          lane                            <= beat_full ? '0 : lane + LANE_W'(1);
        end
        WRITE: begin
          wr_data     <= pack_reg;
          byte_enable <= mask_bytes;
          wr_rq       <= 1'b1;
        end
        WAIT_ACK: begin
          if (action_done) begin
            wr_rq     <= 1'b0;
            wr_adr    <= wr_adr + ADDR_W'(1);
            pack_reg  <= '0;
            lane_mask <= '0;
            if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
`ifdef DDR_PRELOAD_VERIFY_EN
            if (!words_left) begin
              verifying <= 1'b1;
              w         <= '0;
              lane      <= '0;
              rd_adr    <= ADDR_W'(BASE_ADDR);
            end
`else
            if (!words_left) begin
              busy       <= 1'b0;
              setup_done <= 1'b1;
            end
`endif
          end
        end
`ifdef DDR_PRELOAD_VERIFY_EN
        VERIFY: rd_rq <= 1'b1;
        VERIFY_WAIT: begin
          if (rd_valid) begin
            rd_rq     <= 1'b0;
            rd_adr    <= rd_adr + ADDR_W'(1);
            pack_reg  <= '0;
            lane_mask <= '0;
            // Unfilled lanes of pack_reg are zero, so masking only the read data suffices
            if ((rd_data & mask_bits) != pack_reg) verify_fail <= 1'b1;
            if (!words_left) begin
              busy       <= 1'b0;
              setup_done <= 1'b1;
              verifying  <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_preload_packer.sv
// Self-checking bench for ddr_preload_packer: scoreboarded beat writes, handshake holds, reset abort, small config.
// Also exercises read-back verification when DDR_PRELOAD_VERIFY_EN is defined.
module tb_ddr_preload_packer;

  localparam int LANES     = 8;
  localparam int NUM_WORDS = 28;
  localparam int BEATS     = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   src_addr;
  logic [31:0]  src_data;
  logic         wr_rq;
  logic [24:0]  wr_adr;
  logic [255:0] wr_data;
  logic [31:0]  byte_enable;
  logic         action_done = 1'b0;
  logic         busy, setup_done;
  logic [15:0]  beat_cnt;

  logic         start_s = 1'b0;
  logic [9:0]   src_addr_s;
  logic [31:0]  src_data_s;
  logic         wr_rq_s;
  logic [24:0]  wr_adr_s;
  logic [63:0]  wr_data_s;
  logic [7:0]   byte_enable_s;
  logic         action_done_s = 1'b0;
  logic         busy_s, setup_done_s;
  logic [15:0]  beat_cnt_s;

`ifdef DDR_PRELOAD_VERIFY_EN
  logic         rd_rq, rd_rq_s;
  logic [24:0]  rd_adr, rd_adr_s;
  logic [255:0] rd_data = '0;
  logic [63:0]  rd_data_s = '0;
  logic         rd_valid = 1'b0, rd_valid_s = 1'b0;
  logic         verify_fail, verify_fail_s;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [24:0]  adr;
    logic [255:0] data;
    logic [31:0]  be;
    int           idx;
  } beat_t;

  beat_t sb_q[$];

  always #5 clk = ~clk;

  // Registered source ROMs: word[i] = i+1
  always_ff @(posedge clk) src_data   <= 32'(src_addr) + 32'd1;
  always_ff @(posedge clk) src_data_s <= 32'(src_addr_s) + 32'd1;

  ddr_preload_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .src_data(src_data),
    .wr_rq(wr_rq), .wr_adr(wr_adr), .wr_data(wr_data), .byte_enable(byte_enable),
    .action_done(action_done), .busy(busy), .setup_done(setup_done), .beat_cnt(beat_cnt)
`ifdef DDR_PRELOAD_VERIFY_EN
    , .rd_rq(rd_rq), .rd_adr(rd_adr), .rd_data(rd_data), .rd_valid(rd_valid), .verify_fail(verify_fail)
`endif
  );

  ddr_preload_packer #(.NUM_WORDS(1), .DATA_W(64), .BASE_ADDR(25'h1FFFFFF)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .src_addr(src_addr_s), .src_data(src_data_s),
    .wr_rq(wr_rq_s), .wr_adr(wr_adr_s), .wr_data(wr_data_s), .byte_enable(byte_enable_s),
    .action_done(action_done_s), .busy(busy_s), .setup_done(setup_done_s), .beat_cnt(beat_cnt_s)
`ifdef DDR_PRELOAD_VERIFY_EN
    , .rd_rq(rd_rq_s), .rd_adr(rd_adr_s), .rd_data(rd_data_s), .rd_valid(rd_valid_s), .verify_fail(verify_fail_s)
`endif
  );

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t exp_beat(input int b);
    beat_t e;
    e.adr  = 25'(b);
    e.data = '0;
    e.be   = '0;
    e.idx  = b + 1;
    for (int l = 0; l < LANES; l++) begin
      int i;
      i = b * LANES + l;
      if (i < NUM_WORDS) begin
        e.data[l*32 +: 32] = 32'(i + 1);
        e.be[l*4 +: 4]     = 4'hF;
      end
    end
    return e;
  endfunction

  task automatic apply_stimulus_load();
    for (int b = 0; b < BEATS; b++) sb_q.push_back(exp_beat(b));
  endtask

  // Waits for wr_rq; with noise set, action_done is pulsed in every cycle wr_rq is low
  task automatic wait_wr_rq(input bit noise, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (wr_rq) begin
        ok = 1'b1;
        break;
      end
      action_done = noise;
      tick();
    end
    action_done = 1'b0;
  endtask

  task automatic serve_beat(input int delay, input bit noise, input bit watch);
    beat_t        e;
    bit           ok;
    logic [24:0]  a0;
    logic [255:0] d0;
    logic [9:0]   s0;
    int           changes;
    wait_wr_rq(noise, ok);
    check_output("wr_rq_seen", 256'(ok), 256'(1));
    if (!ok) return;
    if (sb_q.size() == 0) begin
      check_output("sb_underflow", 256'(1), 256'(0));
      return;
    end
    e = sb_q.pop_front();
    check_output("wr_adr", 256'(wr_adr), 256'(e.adr));
    check_output("wr_data", wr_data, e.data);
    check_output("byte_enable", 256'(byte_enable), 256'(e.be));
    a0 = wr_adr; d0 = wr_data; s0 = src_addr; changes = 0;
    repeat (delay) begin
      tick();
      if (!wr_rq || wr_adr !== a0 || wr_data !== d0 || src_addr !== s0) changes++;
    end
    if (watch) check_output("hold_stable", 256'(changes), 256'(0));
    action_done = 1'b1;
    tick();
    action_done = 1'b0;
    check_output("wr_rq_drop", 256'(wr_rq), 256'(0));
    check_output("adr_advance", 256'(wr_adr), 256'(e.adr + 25'd1));
    check_output("beat_cnt_step", 256'(beat_cnt), 256'(e.idx));
  endtask

`ifdef DDR_PRELOAD_VERIFY_EN
  task automatic serve_reads(input int flip_beat);
    beat_t        e;
    bit           ok;
    logic [255:0] mask;
    for (int b = 0; b < BEATS; b++) begin
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (rd_rq) begin ok = 1'b1; break; end
        tick();
      end
      check_output("rd_rq_seen", 256'(ok), 256'(1));
      if (!ok) return;
      e = exp_beat(b);
      check_output("rd_adr", 256'(rd_adr), 256'(e.adr));
      for (int k = 0; k < 32; k++) mask[k*8 +: 8] = {8{e.be[k]}};
      rd_data = e.data | ~mask;
      if (b == flip_beat) rd_data[0] = ~rd_data[0];
      tick();
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      check_output("rd_rq_drop", 256'(rd_rq), 256'(0));
    end
  endtask
`endif

  task automatic run_load(input int delay1, input bit noise, input int flip_beat);
    apply_stimulus_load();
    for (int b = 0; b < BEATS; b++) serve_beat((b == 1) ? delay1 : 2, noise, b == 1);
`ifdef DDR_PRELOAD_VERIFY_EN
    check_output("no_done_before_verify", 256'(setup_done), 256'(0));
    serve_reads(flip_beat);
`endif
    for (int i = 0; i < 100; i++) begin
      if (setup_done) break;
      tick();
    end
    check_output("setup_done", 256'(setup_done), 256'(1));
    check_output("busy_done", 256'(busy), 256'(0));
    check_output("beat_cnt_final", 256'(beat_cnt), 256'(BEATS));
`ifdef DDR_PRELOAD_VERIFY_EN
    check_output("verify_fail", 256'(verify_fail), 256'(flip_beat >= 0));
`endif
  endtask

  initial begin
    bit ok;
    $display("[TB] reset values");
    tick();
    tick();
    check_output("rst_wr_rq", 256'(wr_rq), 256'(0));
    check_output("rst_wr_adr", 256'(wr_adr), 256'(0));
    check_output("rst_wr_data", wr_data, 256'(0));
    check_output("rst_byte_enable", 256'(byte_enable), 256'(0));
    check_output("rst_busy", 256'(busy), 256'(0));
    check_output("rst_setup_done", 256'(setup_done), 256'(0));
    check_output("rst_beat_cnt", 256'(beat_cnt), 256'(0));
    check_output("rst_src_addr", 256'(src_addr), 256'(0));
    check_output("rst_s_wr_adr", 256'(wr_adr_s), 256'(25'h1FFFFFF));
    rst_n = 1'b1;
    tick();

    $display("[TB] load 1: ack after 2 cycles, spurious acks while wr_rq low");
    start = 1'b1;
    tick();
    check_output("busy_on_start", 256'(busy), 256'(1));
    run_load(2, 1'b1, -1);

    $display("[TB] start held high through DONE");
    repeat (30) tick();
    check_output("no_retrigger_busy", 256'(busy), 256'(0));
    check_output("no_retrigger_done", 256'(setup_done), 256'(1));

    $display("[TB] load 2: 50-cycle ack on beat 1");
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check_output("done_clear_on_start", 256'(setup_done), 256'(0));
    check_output("busy_on_restart", 256'(busy), 256'(1));
    run_load(50, 1'b0, 2);

    $display("[TB] reset during beat 2 wait");
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    apply_stimulus_load();
    serve_beat(2, 1'b0, 1'b0);
    serve_beat(2, 1'b0, 1'b0);
    wait_wr_rq(1'b0, ok);
    check_output("beat2_rq", 256'(ok), 256'(1));
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_wr_rq", 256'(wr_rq), 256'(0));
    check_output("abort_busy", 256'(busy), 256'(0));
    check_output("abort_setup_done", 256'(setup_done), 256'(0));
    check_output("abort_beat_cnt", 256'(beat_cnt), 256'(0));
    check_output("abort_wr_adr", 256'(wr_adr), 256'(0));
    check_output("abort_wr_data", wr_data, 256'(0));
    check_output("abort_src_addr", 256'(src_addr), 256'(0));
    sb_q.delete();
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    run_load(2, 1'b0, -1);

    $display("[TB] single-word 64-bit configuration at top address");
    start_s = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_rq_s) begin ok = 1'b1; break; end
      tick();
    end
    check_output("s_wr_rq_seen", 256'(ok), 256'(1));
    check_output("s_wr_adr", 256'(wr_adr_s), 256'(25'h1FFFFFF));
    check_output("s_wr_data", 256'(wr_data_s), 256'(64'h1));
    check_output("s_byte_enable", 256'(byte_enable_s), 256'(8'h0F));
    tick();
    action_done_s = 1'b1;
    tick();
    action_done_s = 1'b0;
    check_output("s_wr_adr_wrap", 256'(wr_adr_s), 256'(0));
`ifdef DDR_PRELOAD_VERIFY_EN
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rd_rq_s) begin ok = 1'b1; break; end
      tick();
    end
    check_output("s_rd_rq_seen", 256'(ok), 256'(1));
    check_output("s_rd_adr", 256'(rd_adr_s), 256'(25'h1FFFFFF));
    rd_data_s  = 64'hFFFF_FFFF_0000_0001;
    rd_valid_s = 1'b1;
    tick();
    rd_valid_s = 1'b0;
`endif
    for (int i = 0; i < 50; i++) begin
      if (setup_done_s) break;
      tick();
    end
    check_output("s_setup_done", 256'(setup_done_s), 256'(1));
    check_output("s_beat_cnt", 256'(beat_cnt_s), 256'(1));
    check_output("s_busy", 256'(busy_s), 256'(0));
`ifdef DDR_PRELOAD_VERIFY_EN
    check_output("s_verify_fail", 256'(verify_fail_s), 256'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_preload_packer.md
Name: ddr_preload_packer

Overview:
- Parametrised successor of the fixed 256-bit DDR setup loader.
- On a start command it fetches NUM_WORDS words of WORD_W bits from a source table and packs them little-endian into DATA_W-bit beats.
- Each packed beat is written to DDR through the external RAM controller's wr_rq / wr_adr / wr_data / byte_enable / action_done request interface, using a proper handshake instead of fixed wait counters.
- It sits between the setup command source (PCIe command or test strap) and the Avalon-MM bridge.

Parameters:
WORD_W, 32, source word width; DATA_W must be an integer multiple of it.
DATA_W, 256, DDR beat width; LANES = DATA_W/WORD_W.
ADDR_W, 25, DDR beat address width.
NUM_WORDS, 28, words to load, 1..1024; BEATS = ceil(NUM_WORDS/LANES).
BASE_ADDR, 0, DDR beat address of the first beat.
SRC_AW, 10, source address width; 2^SRC_AW must be >= NUM_WORDS.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level setup request; rising edge is sampled when idle.
src_addr  out  SRC_AW  source word address.
src_data  in  WORD_W  source word, valid exactly 1 cycle after src_addr (registered ROM).
wr_rq  out  1  write request, held until acknowledged.
wr_adr  out  ADDR_W  beat address.
wr_data  out  DATA_W  packed beat.
byte_enable  out  DATA_W/8  byte mask for the beat.
action_done  in  1  1-cycle write acknowledge.
busy  out  1  high from accepted start until DONE is entered.
setup_done  out  1  sticky completion flag.
beat_cnt  out  16  beats written so far.

Behaviour:
- Reset values:
  - All outputs 0.
  - wr_adr = BASE_ADDR.
  - FSM in IDLE.
  - The packing register is cleared.
- FSM states and transitions:
  - IDLE: a start rising edge (start=1 with prior sample 0) -> FETCH. This clears setup_done, sets busy, and zeroes the word index w, lane, and beat_cnt.
  - FETCH: drive src_addr = w -> PACK.
  - PACK: the word returned one cycle later is written into lane (w mod LANES), bits [WORD_W*lane +: WORD_W]. Then w increments.
    - If lane == LANES-1 or w == NUM_WORDS-1 -> WRITE.
    - Otherwise -> FETCH.
  - WRITE: latch wr_data and byte_enable, assert wr_rq -> WAIT_ACK.
  - WAIT_ACK: hold wr_rq, wr_adr, wr_data and byte_enable stable until action_done=1. In the ack cycle, wr_rq drops on the next edge, beat_cnt increments and wr_adr increments by 1.
    - If more words remain -> FETCH. The packing register and mask are cleared for the new beat.
    - Otherwise -> DONE.
  - DONE: setup_done=1 and busy=0 -> IDLE. setup_done stays 1 until the next accepted start.
- Throughput: 2 cycles per word plus handshake, with no fixed waits.
- Byte enables on the final partial beat:
  - Mask bits are set only for filled lanes.
  - Unfilled lanes read as 0.
  - A full beat has byte_enable all ones.
- Addressing:
  - wr_adr wraps modulo 2^ADDR_W.
  - beat_cnt saturates at 16'hFFFF.
- Boundary conditions:
  - start is ignored while busy; a held start does not retrigger after DONE without going low first.
  - action_done outside WAIT_ACK is ignored.
  - action_done arriving in the same cycle wr_rq first rises (WRITE state) is not accepted; it is only valid from WAIT_ACK.
  - rst_n low mid-transfer aborts immediately: wr_rq drops asynchronously, all state returns to reset values, and no partial completion is flagged.
  - NUM_WORDS = 1 produces a single beat with only lane 0 enabled.

Optional Feature:
- Macro: DDR_PRELOAD_VERIFY_EN.
- When defined:
  - Adds ports rd_rq out 1, rd_adr out ADDR_W, rd_data in DATA_W, rd_valid in 1, verify_fail out 1.
  - After the last write ack, the FSM enters VERIFY instead of DONE. It re-reads BEATS beats from BASE_ADDR; for each beat, rd_rq is held until rd_valid.
  - Each read beat is compared under the same byte_enable mask against an expected beat, re-packed from the source in the same way.
  - verify_fail is sticky, cleared on start, and set on the first mismatch. Verification still completes all beats before DONE.
  - setup_done asserts only after VERIFY completes.
- When not defined: the extra ports and VERIFY state are absent, and verify logic must synthesise to nothing.

Test Plan:
- Defaults, src word[i] = i+1, ack 2 cycles after each wr_rq -> 4 beats at addresses 0..3.
  - Beat0 = {32'h8, ..., 32'h1}.
  - Beat3 lanes 0..3 = 32'h19..32'h1C, lanes 4..7 = 0, byte_enable = 32'h0000FFFF.
  - setup_done=1, beat_cnt=4.
- Ack delayed 50 cycles on beat 1 -> wr_rq, wr_adr=1 and wr_data are stable for all 50 cycles, with no extra src_addr activity.
- Start held high through DONE -> exactly one load. Toggling start 0->1 later gives a second load, and setup_done goes low on acceptance.
- rst_n low during beat 2 wait -> wr_rq=0 immediately, all outputs at reset values. A restart completes with 4 beats from address 0.
- NUM_WORDS=1, DATA_W=64, BASE_ADDR=25'h1FFFFFF -> one beat at 25'h1FFFFFF, byte_enable=8'h0F. wr_adr then wraps to 0.
- With DDR_PRELOAD_VERIFY_EN, read beat 2 returned with bit 0 flipped -> verify_fail=1, all 4 reads still issued, then setup_done=1.
